// File: rtl/pll_mdrp_ctrl_pkg.sv
// Shared definitions for the PLL MDRP profile sequencer: opcodes, FSM states,
// register-write entry layout and the two fixed configuration profiles.
package pll_mdrp_ctrl_pkg;

    localparam logic [1:0] MDOPC_NOP = 2'b00;
    localparam logic [1:0] MDOPC_WR  = 2'b01;
    localparam logic [1:0] MDOPC_RD  = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HOLD,
        ST_SEEK,
        ST_WRITE,
        ST_READ,
        ST_RWAIT,
        ST_CHECK,
        ST_RELEASE,
        ST_LOCKWAIT,
        ST_FAIL
    } state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } entry_t;

    localparam int PROFILE_LEN = 4;

    localparam entry_t PROFILE0 [PROFILE_LEN] = '{
        '{addr: 8'h03, data: 8'h21},
        '{addr: 8'h05, data: 8'h03},
        '{addr: 8'h07, data: 8'h03},
        '{addr: 8'h0A, data: 8'h00}
    };

    localparam entry_t PROFILE1 [PROFILE_LEN] = '{
        '{addr: 8'h03, data: 8'h20},
        '{addr: 8'h05, data: 8'h04},
        '{addr: 8'h07, data: 8'h04},
        '{addr: 8'h0A, data: 8'h00}
    };

    function automatic entry_t profile_entry(input logic sel, input logic [1:0] idx);
        return sel ? PROFILE1[idx] : PROFILE0[idx];
    endfunction

endpackage

// File: rtl/pll_mdrp_lock_sync.sv
// Two-flop synchroniser for the PLL lock indication plus the lock timeout
// down-counter; expired asserts once the loaded window has fully elapsed.
module pll_mdrp_lock_sync #(
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_lock,
    input  logic load,
    input  logic run,
    output logic lock_sync,
    output logic expired
);

    localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_lock};
        end
    end

    // Loading TIMEOUT-1 makes the wait window exactly LOCK_TIMEOUT run cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CW'(LOCK_TIMEOUT - 1);
        end else if (run && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign lock_sync = sync_q[1];
    assign expired   = run && (cnt_q == '0);

endmodule

// File: rtl/pll_mdrp_ctrl.sv
// Applies a fixed PLL register profile over the MDRP port with read-back
// verification, then releases PLL reset and waits for lock with a timeout.
//
// state     | meaning
// IDLE      | waiting for start; done pulses here after a successful lock
// HOLD      | PLL held in reset for RST_HOLD cycles
// SEEK      | stepping the MDRP address (with idle gaps) up to the entry addr
// WRITE     | one-cycle write of the entry data
// READ      | one-cycle read of the same address
// RWAIT     | waiting RD_LAT cycles for read data
// CHECK     | compare read-back; next entry, RELEASE or FAIL
// RELEASE   | PLL reset dropped, lock timeout loaded
// LOCKWAIT  | waiting for synchronised lock or timeout
// FAIL      | error raised, back to IDLE
module pll_mdrp_ctrl
    import pll_mdrp_ctrl_pkg::*;
#(
    parameter int NUM_ENTRIES  = 4,
    parameter int RST_HOLD     = 16,
    parameter int RD_LAT       = 2,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       profile_sel,
    input  logic       pll_lock,
    input  logic [7:0] mdrdo,
    output logic       pll_reset,
    output logic [1:0] mdopc,
    output logic       mdainc,
    output logic [7:0] mdwdi,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int RW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    shadow_q, shadow_d;
    logic          gap_q, gap_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [RW-1:0] rd_cnt_q, rd_cnt_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          ainc;
    logic          tmo_load;
    logic          tmo_run;
    logic          lock_sync;
    logic          tmo_expired;
    entry_t        cur;

    assign cur     = profile_entry(sel_q, idx_q[1:0]);
    assign tmo_run = (state_q == ST_LOCKWAIT);

    pll_mdrp_lock_sync #(
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) u_lock_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .pll_lock (pll_lock),
        .load     (tmo_load),
        .run      (tmo_run),
        .lock_sync(lock_sync),
        .expired  (tmo_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= 1'b0;
            idx_q      <= '0;
            shadow_q   <= '0;
            gap_q      <= 1'b0;
            hold_cnt_q <= '0;
            rd_cnt_q   <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            gap_q      <= gap_d;
            hold_cnt_q <= hold_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        gap_d      = gap_q;
        hold_cnt_d = hold_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        done_d     = 1'b0;
        error_d    = error_q;
        ainc       = 1'b0;
        tmo_load   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d      = profile_sel;
                    error_d    = 1'b0;
                    idx_d      = '0;
                    hold_cnt_d = HW'(RST_HOLD - 1);
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == '0) begin
                    gap_d   = 1'b0;
                    state_d = ST_SEEK;
                end else begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end
            end
            ST_SEEK: begin
                // gap_q forces an idle cycle after every increment strobe
                if (shadow_q == cur.addr) begin
                    gap_d   = 1'b0;
                    state_d = ST_WRITE;
                end else if (gap_q) begin
                    gap_d = 1'b0;
                end else begin
                    ainc     = 1'b1;
                    shadow_d = shadow_q + 8'd1;
                    gap_d    = 1'b1;
                end
            end
            ST_WRITE: begin
                state_d = ST_READ;
            end
            ST_READ: begin
                rd_cnt_d = RW'(RD_LAT - 1);
                state_d  = ST_RWAIT;
            end
            ST_RWAIT: begin
                if (rd_cnt_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    rd_cnt_d = rd_cnt_q - RW'(1);
                end
            end
            ST_CHECK: begin
                if (mdrdo != cur.data) begin
                    error_d = 1'b1;
                    state_d = ST_FAIL;
                end else if (idx_q == 8'(NUM_ENTRIES - 1)) begin
                    state_d = ST_RELEASE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = ST_SEEK;
                end
            end
            ST_RELEASE: begin
                tmo_load = 1'b1;
                state_d  = ST_LOCKWAIT;
            end
            ST_LOCKWAIT: begin
                if (lock_sync) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo_expired) begin
                    error_d = 1'b1;
                    state_d = ST_FAIL;
                end
            end
            ST_FAIL: begin
                error_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode straight from registered state so reset clears them at once.
    assign pll_reset = state_q inside {ST_HOLD, ST_SEEK, ST_WRITE, ST_READ, ST_RWAIT, ST_CHECK};
    assign busy      = !(state_q inside {ST_IDLE, ST_FAIL});
    assign done      = done_q;
    assign error     = error_q;
    assign mdainc    = ainc;
    assign mdopc     = (state_q == ST_WRITE) ? MDOPC_WR :
                       (state_q == ST_READ)  ? MDOPC_RD : MDOPC_NOP;
    assign mdwdi     = (state_q == ST_WRITE) ? cur.data : 8'h00;

endmodule

// File: tb/tb_pll_mdrp_ctrl.sv
// Scoreboard bench for pll_mdrp_ctrl: a behavioural PLL register file drives
// mdrdo/pll_lock, and a profile-level reference predicts writes and outcomes.
module tb_pll_mdrp_ctrl;

    localparam int NUM_ENTRIES  = 4;
    localparam int RST_HOLD     = 16;
    localparam int RD_LAT       = 2;
    localparam int LOCK_TIMEOUT = 300;

    localparam logic [1:0] OPC_WR = 2'b01;
    localparam logic [1:0] OPC_RD = 2'b10;
    localparam logic [1:0] K_WR   = 2'd0;
    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       profile_sel = 1'b0;
    logic       pll_lock = 1'b0;
    logic [7:0] mdrdo = 8'h00;
    logic       pll_reset;
    logic [1:0] mdopc;
    logic       mdainc;
    logic [7:0] mdwdi;
    logic       busy;
    logic       done;
    logic       error;

    always #5 clk = ~clk;

    pll_mdrp_ctrl #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .RST_HOLD    (RST_HOLD),
        .RD_LAT      (RD_LAT),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .profile_sel(profile_sel),
        .pll_lock   (pll_lock),
        .mdrdo      (mdrdo),
        .pll_reset  (pll_reset),
        .mdopc      (mdopc),
        .mdainc     (mdainc),
        .mdwdi      (mdwdi),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    logic [7:0] ref_addr [2][4] = '{'{8'h03, 8'h05, 8'h07, 8'h0A}, '{8'h03, 8'h05, 8'h07, 8'h0A}};
    logic [7:0] ref_data [2][4] = '{'{8'h21, 8'h03, 8'h03, 8'h00}, '{8'h20, 8'h04, 8'h04, 8'h00}};
    logic [7:0] ref_shadow = 8'h00;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] val;
    } ev_t;
    ev_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // PLL model state
    logic [7:0] pll_mem [256];
    logic [7:0] pll_addr = 8'h00;
    logic [7:0] rd_val = 8'h00;
    logic [7:0] corrupt_mask = 8'h00;
    int rd_wait = 0;
    int rd_count = 0;
    int corrupt_rd = -1;
    int lock_delay = -1;
    int rel_cnt = 0;

    // monitor state
    logic prev_ainc = 1'b0;
    logic prev_done = 1'b0;
    logic prev_err = 1'b0;
    int ainc_count = 0;
    int wr_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_event(input string name, input logic [1:0] kind, input logic [15:0] val);
        ev_t ev;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected event kind %0d val 0x%0h, none expected at %0t", name, kind, val, $time);
        end else begin
            ev = exp_q.pop_front();
            check({name, "_kind"}, 32'(kind), 32'(ev.kind));
            if (ev.kind == K_WR && kind == K_WR) check({name, "_addr_data"}, 32'(val), 32'(ev.val));
        end
    endtask

    // Behavioural PLL: address pointer, register file, delayed read data, lock.
    always @(negedge clk) begin
        if (!rst_n) begin
            pll_addr = 8'h00;
            rd_wait  = 0;
        end else begin
            if (mdainc) pll_addr = pll_addr + 8'd1;
            if (mdopc == OPC_WR) pll_mem[pll_addr] = mdwdi;
            if (rd_wait > 0) begin
                rd_wait--;
                if (rd_wait == 0) mdrdo = rd_val;
            end
            if (mdopc == OPC_RD) begin
                rd_val = pll_mem[pll_addr];
                if (rd_count == corrupt_rd) rd_val = rd_val ^ corrupt_mask;
                rd_count++;
                rd_wait = RD_LAT;
                mdrdo = ~rd_val;
            end
        end
        if (pll_reset) rel_cnt = 0;
        else rel_cnt++;
        pll_lock = (lock_delay >= 0) && (rel_cnt >= lock_delay);
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ainc = 1'b0;
            prev_done = 1'b0;
            prev_err  = 1'b0;
        end else begin
            if (mdainc) begin
                ainc_count++;
                check("mdainc_idle_gap", 32'(prev_ainc), 0);
            end
            if (mdopc != OPC_WR) check("mdwdi_idle_zero", 32'(mdwdi), 0);
            if (mdopc == OPC_WR) begin
                wr_count++;
                expect_event("write", K_WR, {pll_addr, mdwdi});
            end
            if (done) begin
                check("done_single_pulse", 32'(prev_done), 0);
                expect_event("done", K_DONE, 16'h0000);
            end
            if (error && !prev_err) expect_event("error", K_ERR, 16'h0000);
            prev_ainc = mdainc;
            prev_done = done;
            prev_err  = error;
        end
    end

    task automatic run_seq(input bit sel, input int fail_idx, input logic [7:0] mask,
                           input int ldelay, input bit poke);
        int   pulses_exp;
        int   wr_exp;
        int   rel_at;
        int   end_at;
        int   diff;
        bit   failing;
        bit   fin;
        ev_t  e;
        logic [7:0] cur;

        cur = ref_shadow;
        pulses_exp = 0;
        wr_exp = 0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            pulses_exp += int'(8'(ref_addr[sel][i] - cur));
            cur = ref_addr[sel][i];
            e.kind = K_WR;
            e.val  = {ref_addr[sel][i], ref_data[sel][i]};
            exp_q.push_back(e);
            wr_exp++;
            if (i == fail_idx) break;
        end
        ref_shadow = cur;
        failing = (fail_idx >= 0) || (ldelay < 0);
        e.kind = failing ? K_ERR : K_DONE;
        e.val  = 16'h0000;
        exp_q.push_back(e);

        corrupt_rd   = fail_idx;
        corrupt_mask = mask;
        lock_delay   = ldelay;
        rd_count     = 0;

        @(negedge clk);
        start       = 1'b1;
        profile_sel = sel;
        ainc_count  = 0;
        wr_count    = 0;
        @(negedge clk);
        start       = 1'b0;
        profile_sel = 1'($urandom);
        check("busy_after_start", 32'(busy), 1);
        check("error_cleared_on_start", 32'(error), 0);
        check("pll_reset_after_start", 32'(pll_reset), 1);

        fin = 1'b0;
        rel_at = -1;
        end_at = -1;
        for (int c = 0; c < 4000 && !fin; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (rel_at < 0 && !pll_reset) rel_at = c;
            if (done || error) begin
                fin = 1'b1;
                end_at = c;
            end else if (poke && c == 20 && busy) begin
                start = 1'b1;
                profile_sel = ~sel;
            end
        end
        start = 1'b0;
        check("sequence_finished", 32'(fin), 1);
        check("mdainc_pulse_count", 32'(ainc_count), 32'(pulses_exp));
        check("write_count", 32'(wr_count), 32'(wr_exp));
        check("error_at_end", 32'(error), 32'(failing));
        check("busy_at_end", 32'(busy), 0);
        check("pll_reset_at_end", 32'(pll_reset), 0);
        if (fail_idx < 0 && ldelay < 0) begin
            diff = end_at - rel_at;
            checks++;
            if (diff < LOCK_TIMEOUT - 1 || diff > LOCK_TIMEOUT + 3) begin
                errors++;
                $display("FAIL lock_timeout_latency: got %0d cycles, expected %0d +/-2", diff, LOCK_TIMEOUT + 1);
            end
        end
        @(negedge clk);
        check("done_low_after_pulse", 32'(done), 0);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
    endtask

    task automatic reset_during_seek();
        bit seen;
        @(negedge clk);
        start = 1'b1;
        profile_sel = 1'($urandom);
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (mdainc) seen = 1'b1;
        end
        check("seek_reached_before_reset", 32'(seen), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_pll_reset", 32'(pll_reset), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_error", 32'(error), 0);
        check("abort_mdopc", 32'(mdopc), 0);
        check("abort_mdainc", 32'(mdainc), 0);
        check("abort_mdwdi", 32'(mdwdi), 0);
        exp_q.delete();
        ref_shadow = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int mode;
        for (int i = 0; i < 256; i++) pll_mem[i] = 8'h00;

        repeat (3) @(negedge clk);
        check("reset_pll_reset", 32'(pll_reset), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_error", 32'(error), 0);
        check("reset_mdopc", 32'(mdopc), 0);
        check("reset_mdainc", 32'(mdainc), 0);
        check("reset_mdwdi", 32'(mdwdi), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_seq(1'b0, -1, 8'h00, 100, 1'b0);   // profile 0, clean lock
        run_seq(1'b1, -1, 8'h00, 100, 1'b1);   // address wrap 0x0A->0x03, start poked while busy
        run_seq(1'b0, 0, 8'h03, 100, 1'b0);    // first read returns 0x22
        run_seq(1'b0, -1, 8'h00, -1, 1'b0);    // lock never arrives
        reset_during_seek();
        run_seq(1'b0, -1, 8'h00, 10, 1'b0);    // shadow restarts at 0x00

        for (int n = 0; n < 8; n++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0, 1: run_seq(1'($urandom), -1, 8'h00, int'($urandom_range(0, 200)), 1'($urandom));
                2: run_seq(1'($urandom), int'($urandom_range(0, NUM_ENTRIES - 1)),
                           8'($urandom_range(1, 255)), 50, 1'($urandom));
                default: run_seq(1'($urandom), -1, 8'h00, -1, 1'b0);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_mdrp_ctrl.md
PLL_MDRP_CTRL -- requirements
Module: pll_mdrp_ctrl

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 4; number of {addr,data} register writes per profile.
REQ-002 SHALL have parameter RST_HOLD, default 16; clk cycles pll_reset is held before the first MDRP access.
REQ-003 SHALL have parameter RD_LAT, default 2; clk cycles from a READ opcode to valid mdrdo.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 65535; clk cycles allowed for pll_lock after reset release.
REQ-005 SHALL have port clk, input, 1; the single clock; also drives the PLL mdclk.
REQ-006 SHALL have port rst_n, input, 1; asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1; one-cycle request to apply the selected profile.
REQ-008 SHALL have port profile_sel, input, 1; selects the profile table, sampled when start is accepted.
REQ-009 SHALL have port pll_lock, input, 1; PLL lock, two-flop synchronised internally.
REQ-010 SHALL have port mdrdo, input, 8; PLL MDRP read data.
REQ-011 SHALL have port pll_reset, output, 1; active-high PLL reset.
REQ-012 SHALL have ports mdopc (output, 2), mdainc (output, 1) and mdwdi (output, 8); MDRP opcode, address-increment strobe and write data.
REQ-013 SHALL have ports busy, done and error (each output, 1); sequence active, success pulse, and sticky failure.

Function
REQ-014 States SHALL be IDLE, HOLD, SEEK, WRITE, READ, RWAIT, CHECK, RELEASE, LOCKWAIT and FAIL.
REQ-015 IDLE: start=1 SHALL latch profile_sel, clear error, clear the entry index, assert pll_reset and busy, and go to HOLD.
REQ-016 start SHALL be ignored while busy=1.
REQ-017 HOLD SHALL count RST_HOLD cycles, then go to SEEK.
REQ-018 SEEK SHALL pulse mdainc for one cycle per step, with at least one idle cycle between pulses.
REQ-019 SEEK SHALL advance an 8-bit shadow address (mod 256, wrap 0xFF->0x00) until it equals the entry addr, then go to WRITE.
REQ-020 WRITE SHALL drive mdopc=WR and mdwdi=entry data for exactly one cycle, then go to READ.
REQ-021 READ SHALL drive mdopc=RD for one cycle, then go to RWAIT.
REQ-022 RWAIT SHALL wait RD_LAT cycles, then go to CHECK.
REQ-023 CHECK SHALL compare mdrdo to the entry data: on mismatch go to FAIL; on match go to SEEK for the next entry, or to RELEASE after entry NUM_ENTRIES-1.
REQ-024 RELEASE SHALL deassert pll_reset, load the timeout counter, and go to LOCKWAIT.
REQ-025 LOCKWAIT: when synchronised lock=1, busy SHALL clear and done SHALL pulse for one cycle; on counter expiry, go to FAIL.
REQ-026 FAIL SHALL set error (sticky until the next accepted start), deassert pll_reset, clear busy and return to IDLE.
REQ-027 Outside WRITE and READ, mdopc SHALL be NOP and mdwdi SHALL be 0x00.
REQ-028 The shadow address SHALL persist across sequences; the first sequence after reset SHALL assume address 0x00.
REQ-029 Reset mid-sequence SHALL abort immediately with all outputs at their reset values.

Reset
REQ-030 While rst_n=0: state=IDLE, pll_reset=0, busy=0, done=0, error=0, mdopc=NOP, mdainc=0, mdwdi=0x00, shadow address=0x00, all counters=0.

Structure
REQ-031 A shared package SHALL hold the MDRP opcode constants (NOP=2'b00, WR=2'b01, RD=2'b10), the state enum, the entry typedef {addr[7:0], data[7:0]} and both profile tables as constant arrays.
REQ-032 Profile 0 SHALL be {0x03,0x21},{0x05,0x03},{0x07,0x03},{0x0A,0x00}; profile 1 SHALL be {0x03,0x20},{0x05,0x04},{0x07,0x04},{0x0A,0x00}.
REQ-033 One sub-module, pll_mdrp_lock_sync (the 2-flop synchroniser plus timeout counter), SHALL be instantiated.

Verification
REQ-034 Profile 0, PLL model echoing writes, lock 100 cycles after release: exactly 0x0A mdainc pulses, 4 WR cycles with data 0x21,0x03,0x03,0x00, done pulses once, error=0.
REQ-035 Model returns 0x22 on the first read: FAIL reached after entry 0, exactly 1 WR, error=1, pll_reset=0, busy=0.
REQ-036 pll_lock held at 0: done never pulses, error=1 exactly LOCK_TIMEOUT+1 cycles after RELEASE (±2 for the synchroniser).
REQ-037 Profile 1 run after profile 0: shadow address wraps 0x0A->0xFF->0x03, i.e. 249 mdainc pulses before the first write.
REQ-038 start re-asserted while busy: no effect; rst_n low during SEEK: all outputs return to reset values within the same cycle.
